// File: rtl/adder_pkg.sv
// Shared definitions for the sequential adder: FSM state encodings
// and a constant clog2 used to size the chunk counter.
package adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_n.sv
// Combinational N-bit ripple adder, generalised form of adder_32.
// Ports: a, b, c_in -> s, c_out (carry out of MSB), c_msb (carry into MSB).
module adder_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] s,
    output logic         c_out,
    output logic         c_msb
);

    logic cy;

    always_comb begin
        s     = '0;
        c_msb = 1'b0;
        cy    = c_in;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) begin
                c_msb = cy;
            end
            s[i] = a[i] ^ b[i] ^ cy;
            cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        c_out = cy;
    end

endmodule

// File: rtl/adder_seq.sv
// Multi-cycle add/subtract, CHUNK bits per clock, LSB chunk first.
// Ports: clk, rst, start, sub, a, b, c_in -> busy, done, s, c_out, ovf, zero.
module adder_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = clog2(NCHUNK) + 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("adder_seq: WIDTH must be a multiple of CHUNK");
    end

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] full;

    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic [CHUNK-1:0] cs;
    logic             cc;
    logic             cm;
    int               base;
    logic             accept;

    // Select the current chunk of each operand by the counter.
    always_comb begin
        base = int'(cnt) * CHUNK;
        ca   = a_r[base +: CHUNK];
        cb   = b_r[base +: CHUNK];
    end

    adder_n #(
        .N(CHUNK)
    ) u_add (
        .a    (ca),
        .b    (cb),
        .c_in (carry),
        .s    (cs),
        .c_out(cc),
        .c_msb(cm)
    );

    // Accumulated sum with the chunk being computed this cycle merged in.
    always_comb begin
        full              = acc;
        full[base +: CHUNK] = cs;
    end

    assign accept = start && (state != ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_RUN) begin
                carry <= cc;
                acc   <= full;
                if (cnt == LAST) begin
                    s     <= full;
                    c_out <= cc;
                    // Last chunk holds the MSB, so its carries give overflow.
                    ovf   <= cm ^ cc;
                    zero  <= (full == '0);
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (accept) begin
                // Subtract as a + ~b + ~c_in; c_out=1 then means no borrow.
                a_r   <= a;
                b_r   <= sub ? ~b : b;
                carry <= c_in ^ sub;
                cnt   <= '0;
                acc   <= '0;
                busy  <= 1'b1;
                state <= ST_RUN;
            end else begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_adder_seq.sv
// Self-checking bench for adder_seq across several WIDTH/CHUNK pairs.
// Directed table, handshake corner sequences and a random sweep.
module tb_adder_seq;

    logic        clk;
    logic        rst;
    logic [3:0]  st;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        c_in;

    wire [3:0]  bz;
    wire [3:0]  dn;
    wire [3:0]  co;
    wire [3:0]  ov;
    wire [3:0]  zr;
    wire [31:0] s0;
    wire [31:0] s1;
    wire [31:0] s2;
    wire [15:0] s3;

    int n_chk;
    int n_err;

    adder_seq #(.WIDTH(32), .CHUNK(8)) u0 (
        .clk(clk), .rst(rst), .start(st[0]), .sub(sub), .a(a), .b(b),
        .c_in(c_in), .busy(bz[0]), .done(dn[0]), .s(s0), .c_out(co[0]),
        .ovf(ov[0]), .zero(zr[0]));

    adder_seq #(.WIDTH(32), .CHUNK(1)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .sub(sub), .a(a), .b(b),
        .c_in(c_in), .busy(bz[1]), .done(dn[1]), .s(s1), .c_out(co[1]),
        .ovf(ov[1]), .zero(zr[1]));

    adder_seq #(.WIDTH(32), .CHUNK(32)) u2 (
        .clk(clk), .rst(rst), .start(st[2]), .sub(sub), .a(a), .b(b),
        .c_in(c_in), .busy(bz[2]), .done(dn[2]), .s(s2), .c_out(co[2]),
        .ovf(ov[2]), .zero(zr[2]));

    adder_seq #(.WIDTH(16), .CHUNK(4)) u3 (
        .clk(clk), .rst(rst), .start(st[3]), .sub(sub), .a(a[15:0]),
        .b(b[15:0]), .c_in(c_in), .busy(bz[3]), .done(dn[3]), .s(s3),
        .c_out(co[3]), .ovf(ov[3]), .zero(zr[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sb;
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    function automatic logic [31:0] s_of(input int i);
        case (i)
            0:       return s0;
            1:       return s1;
            2:       return s2;
            default: return {16'h0, s3};
        endcase
    endfunction

    function automatic int w_of(input int i);
        return (i == 3) ? 16 : 32;
    endfunction

    function automatic int nch_of(input int i);
        case (i)
            0:       return 4;
            1:       return 32;
            2:       return 1;
            default: return 4;
        endcase
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed values.
    function automatic void model(input int w, input logic sb,
                                  input logic [31:0] x, input logic [31:0] y,
                                  input logic ci, output logic [31:0] rs,
                                  output logic rc, output logic ro,
                                  output logic rz);
        longint m, half, ux, uy, r, sx, sy, sr, cv;
        m    = longint'(1) << w;
        half = m / 2;
        ux   = longint'({32'h0, x}) & (m - 1);
        uy   = longint'({32'h0, y}) & (m - 1);
        cv   = ci ? 1 : 0;
        r    = sb ? (ux - uy - cv) : (ux + uy + cv);
        rs   = 32'(r & (m - 1));
        rc   = sb ? (r >= 0) : (r >= m);
        sx   = (ux >= half) ? ux - m : ux;
        sy   = (uy >= half) ? uy - m : uy;
        sr   = sb ? (sx - sy - cv) : (sx + sy + cv);
        ro   = (sr >= half) || (sr < -half);
        rz   = (rs == 32'h0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input int idx, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!dn[idx] && n < 200);
        chk($sformatf("u%0d_done_seen", idx), 32'(dn[idx]), 32'd1);
    endtask

    task automatic run_op(input int idx, input logic sb, input logic [31:0] x,
                          input logic [31:0] y, input logic ci,
                          input logic [31:0] es, input logic ec,
                          input logic eo, input logic ez);
        int n;
        @(negedge clk);
        sub  = sb;
        a    = x;
        b    = y;
        c_in = ci;
        st[idx] = 1'b1;
        @(posedge clk);
        #1;
        st[idx] = 1'b0;
        wait_done(idx, n);
        chk($sformatf("u%0d_lat", idx), 32'(n + 1), 32'(nch_of(idx) + 1));
        chk($sformatf("u%0d_s a=%h b=%h sub=%b ci=%b", idx, x, y, sb, ci),
            s_of(idx), es);
        chk($sformatf("u%0d_c", idx), 32'(co[idx]), 32'(ec));
        chk($sformatf("u%0d_ovf", idx), 32'(ov[idx]), 32'(eo));
        chk($sformatf("u%0d_zero", idx), 32'(zr[idx]), 32'(ez));
    endtask

    vec_t tv[6];

    initial begin
        int          n;
        logic [31:0] prev;
        logic [31:0] rs;
        logic        rc, ro, rz;
        logic [31:0] x, y;
        logic        sb, ci;

        n_chk = 0;
        n_err = 0;

        tv[0] = '{1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1};
        tv[1] = '{1'b0, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        tv[2] = '{1'b1, 32'h5, 32'h7, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        tv[3] = '{1'b1, 32'h7, 32'h5, 1'b0, 32'h2, 1'b1, 1'b0, 1'b0};
        tv[4] = '{1'b1, 32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        tv[5] = '{1'b1, 32'h5, 32'h5, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};

        rst  = 1'b1;
        st   = 4'h0;
        sub  = 1'b0;
        a    = 32'h0;
        b    = 32'h0;
        c_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("u%0d_rst_s", i), s_of(i), 32'h0);
            chk($sformatf("u%0d_rst_flags", i),
                {27'h0, bz[i], dn[i], co[i], ov[i], zr[i]}, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(0, tv[i].sb, tv[i].a, tv[i].b, tv[i].ci,
                   tv[i].s, tv[i].c, tv[i].o, tv[i].z);
        end
        prev = tv[5].s;

        // Start ignored mid-RUN, then held high to re-issue from DONE.
        @(negedge clk);
        sub  = 1'b0;
        a    = 32'h1;
        b    = 32'h2;
        c_in = 1'b0;
        st[0] = 1'b1;
        @(posedge clk);
        #1;
        a = 32'h12345678;
        b = 32'h12345678;
        n = 1;
        do begin
            chk("hold_s", s0, prev);
            chk("hold_busy", 32'(bz[0]), 32'd1);
            @(posedge clk);
            #1;
            n++;
        end while (!dn[0] && n < 50);
        chk("b2b_lat1", 32'(n), 32'd5);
        chk("b2b_s1", s0, 32'h3);
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        chk("b2b_pulse", 32'(dn[0]), 32'd0);
        chk("b2b_busy", 32'(bz[0]), 32'd1);
        wait_done(0, n);
        chk("b2b_lat2", 32'(n + 1), 32'd5);
        chk("b2b_s2", s0, 32'h2468ACF0);

        // Reset during RUN aborts and clears the result.
        @(negedge clk);
        a = 32'h3;
        b = 32'h4;
        st[0] = 1'b1;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_s", s0, 32'h0);
        chk("abort_flags", {27'h0, bz[0], dn[0], co[0], ov[0], zr[0]}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (dn[0]) n++;
        end
        chk("abort_no_done", 32'(n), 32'd0);
        run_op(0, 1'b0, 32'h3, 32'h4, 1'b0, 32'h7, 1'b0, 1'b0, 1'b0);

        // Random sweep against the reference model.
        for (int idx = 0; idx < 4; idx++) begin
            for (int k = 0; k < 250; k++) begin
                x  = $urandom;
                y  = $urandom;
                if (k % 10 == 0) y = x;
                sb = 1'($urandom_range(0, 1));
                ci = 1'($urandom_range(0, 1));
                model(w_of(idx), sb, x, y, ci, rs, rc, ro, rz);
                run_op(idx, sb, x, y, ci, rs, rc, ro, rz);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
